// File: rtl/oai_sweep_bist.sv
// Exhaustive sweeper/checker for a GROUPS x GROUP_W OAI cell: ZN = ~&(|group).
// Latency: SETTLE+1 cycles per vector, 2^N*(SETTLE+1) cycles from first HOLD cycle to done.
// Backpressure: none; start is a pulse honoured only when idle or done, ignored while busy.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin a sweep (ignored while busy)
//   dut_zn              ZN returned by the device under test
//   vec_out [N-1:0]     stimulus; bit N-1 = group0 input0, bit 0 = last input of last group
//   exp_zn              golden ZN for vec_out (combinational)
//   busy, done, pass    status; done/pass held until the next accepted start
//   err_count [N:0]     mismatches this sweep (non-saturating, max 2^N)
//   first_fail_vec/_valid  vector of the first mismatch and its capture flag
//
// Optional feature: define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch,
// leaving vec_out on the failing vector.

module oai_sweep_bist #(
  parameter int GROUPS  = 2,
  parameter int GROUP_W = 3,
  parameter int SETTLE  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         dut_zn,
  output logic [GROUPS*GROUP_W-1:0]    vec_out,
  output logic                         exp_zn,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [GROUPS*GROUP_W:0]      err_count,
  output logic [GROUPS*GROUP_W-1:0]    first_fail_vec,
  output logic                         first_fail_valid
);

  localparam int N  = GROUPS * GROUP_W;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      err_q, err_d;
  logic [N-1:0]    ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;
  logic            pass_q, pass_d;

  // Golden function: each group's inputs occupy a contiguous slice, group 0 at the MSBs.
  logic [GROUPS-1:0] grp_hit;
  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    assign grp_hit[g] = |vec_q[N-1-g*GROUP_W -: GROUP_W];
  end
  assign exp_zn = ~&grp_hit;

  // Case-inequality so an X/Z from the cell under test is counted as a failure.
  logic mismatch;
  assign mismatch = (dut_zn !== exp_zn);

  logic stop_now;
`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = HOLD;
          vec_d     = '0;
          cnt_d     = '0;
          err_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
        end
      end

      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      CHECK: begin
        if (mismatch) begin
          err_d = err_q + (N+1)'(1);
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        if (stop_now) begin
          // Leave vec_out on the failing vector for inspection.
          state_d = DONE;
          pass_d  = 1'b0;
        end else if (&vec_q) begin
          state_d = DONE;
          vec_d   = '0;
          // Includes this final vector's result, so it uses the next-state count.
          pass_d  = (err_d == '0);
        end else begin
          state_d = HOLD;
          vec_d   = vec_q + N'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = (state_q == HOLD) || (state_q == CHECK);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule
